// File: rtl/interp_pkg.sv
// Shared types, constants and the saturating ROM address helper for the
// interpolation LUT scheduler.
package interp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_LAST = 3'd4,
        ST_CALC = 3'd5,
        ST_RESP = 3'd6
    } state_t;

    localparam logic       MODE_LIN   = 1'b0;
    localparam logic       MODE_QUAD  = 1'b1;
    localparam logic [6:0] ROM64_LAST = 7'd63;

    // Sum is formed at 7 bits so addresses near the top clamp instead of wrapping to 0.
    function automatic logic [5:0] sat_addr(input logic [5:0] base, input logic [1:0] offs);
        logic [6:0] sum;
        sum = {1'b0, base} + {5'd0, offs};
        if (sum > ROM64_LAST) begin
            return ROM64_LAST[5:0];
        end else begin
            return sum[5:0];
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer holds the last grant, priority starts one
// past it, and the pointer moves only when the grant is taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // First requester found scanning upward from pointer+1 wins.
    always_comb begin : search
        logic          w_found;
        logic          w_hit;
        logic [PW-1:0] w_idx;
        grant   = {N{1'b0}};
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_idx   = {PW{1'b0}};
        for (int k = 1; k <= N; k++) begin
            w_idx        = PW'((int'(r_ptr) + k) % N);
            w_hit        = !w_found && req[w_idx];
            grant[w_idx] = grant[w_idx] | w_hit;
            w_found      = w_found | w_hit;
        end
    end

    // Index of the current winner, used as the new pointer value.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N; i++) begin
            w_ptr_nxt = grant[i] ? PW'(i) : w_ptr_nxt;
        end
    end

    // Pointer register; reset to N-1 so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= PW'(N - 1);
        end else if (advance) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/interp_lut_scheduler.sv
// Arbitrates requesters onto one synchronous coarse-sample ROM port and the
// shared linear/quadratic interpolators, returning each result with its ID.
module interp_lut_scheduler
    import interp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_x,
    input  logic [N_REQ-1:0]   req_mode,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rom_en,
    output logic [5:0]         rom_addr,
    input  logic [7:0]         rom_data,
    output logic [7:0]         y_1,
    output logic [7:0]         y_2,
    output logic [7:0]         y_3,
    output logic [1:0]         xlsb,
    input  logic [7:0]         lin_y,
    input  logic [7:0]         quad_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [7:0]         rsp_y,
    output logic               busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] w_grant;
    logic             w_accept;
    logic [7:0]       w_win_x;
    logic             w_win_mode;
    logic [IDW-1:0]   w_win_id;
    logic [7:0]       w_x_cur;
    logic             w_rom_en_nxt;
    logic [5:0]       w_rom_addr_nxt;

    logic [7:0]       r_x;
    logic             r_mode;
    logic [IDW-1:0]   r_gid;
    logic             r_rom_en;
    logic [5:0]       r_rom_addr;
    logic [7:0]       r_y1;
    logic [7:0]       r_y2;
    logic [7:0]       r_y3;
    logic [7:0]       r_rsp_y;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_valid;
    logic             r_busy;

    assign w_accept = rst_n && (r_state == ST_IDLE) && (|req_valid);

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant)
    );

    assign req_ready = w_accept ? w_grant : {N_REQ{1'b0}};

    // Select the winning requester's x, mode and index from the one-hot grant.
    always_comb begin
        w_win_x    = 8'd0;
        w_win_mode = 1'b0;
        w_win_id   = {IDW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_win_x    = w_grant[i] ? req_x[8*i +: 8] : w_win_x;
            w_win_mode = w_grant[i] ? req_mode[i]     : w_win_mode;
            w_win_id   = w_grant[i] ? IDW'(i)         : w_win_id;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = (|req_valid) ? ST_RD0 : ST_IDLE;
            ST_RD0:  w_state_nxt = ST_RD1;
            ST_RD1:  w_state_nxt = ST_RD2;
            ST_RD2:  w_state_nxt = (r_mode == MODE_QUAD) ? ST_LAST : ST_CALC;
            ST_LAST: w_state_nxt = ST_CALC;
            ST_CALC: w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ROM controls are decoded from the next state so the registered port is
    // already driven in the cycle the FSM sits in RD0/RD1/RD2.
    assign w_x_cur = (r_state == ST_IDLE) ? w_win_x : r_x;

    // Output decode for the ROM port.
    always_comb begin
        w_rom_en_nxt   = 1'b0;
        w_rom_addr_nxt = 6'd0;
        case (w_state_nxt)
            ST_RD0: begin
                w_rom_en_nxt   = 1'b1;
                w_rom_addr_nxt = w_x_cur[7:2];
            end
            ST_RD1: begin
                w_rom_en_nxt   = 1'b1;
                w_rom_addr_nxt = sat_addr(r_x[7:2], 2'd1);
            end
            ST_RD2: begin
                w_rom_en_nxt   = (r_mode == MODE_QUAD);
                w_rom_addr_nxt = (r_mode == MODE_QUAD) ? sat_addr(r_x[7:2], 2'd2) : 6'd0;
            end
            default: begin
                w_rom_en_nxt   = 1'b0;
                w_rom_addr_nxt = 6'd0;
            end
        endcase
    end

    // Transaction latches, sample capture, result register and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x         <= 8'd0;
            r_mode      <= 1'b0;
            r_gid       <= {IDW{1'b0}};
            r_rom_en    <= 1'b0;
            r_rom_addr  <= 6'd0;
            r_y1        <= 8'd0;
            r_y2        <= 8'd0;
            r_y3        <= 8'd0;
            r_rsp_y     <= 8'd0;
            r_rsp_id    <= {IDW{1'b0}};
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rom_en    <= w_rom_en_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_x    <= w_win_x;
                r_mode <= w_win_mode;
                r_gid  <= w_win_id;
            end
            if (r_state == ST_RD1) begin
                r_y1 <= rom_data;
            end
            if (r_state == ST_RD2) begin
                r_y2 <= rom_data;
            end
            if (r_state == ST_LAST) begin
                r_y3 <= rom_data;
            end
            if (r_state == ST_CALC) begin
                r_rsp_y  <= (r_mode == MODE_LIN) ? lin_y : quad_y;
                r_rsp_id <= r_gid;
            end
        end
    end

    assign rom_en    = r_rom_en;
    assign rom_addr  = r_rom_addr;
    assign y_1       = r_y1;
    assign y_2       = r_y2;
    assign y_3       = r_y3;
    assign xlsb      = r_x[1:0];
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign busy      = r_busy;

endmodule

// File: tb/tb_interp_lut_scheduler.sv
// Scoreboard bench for interp_lut_scheduler: bench-side ROM and interpolators,
// a request-level reference model, and a negedge monitor that checks responses.
module tb_interp_lut_scheduler;

    localparam int N   = 4;
    localparam int IDW = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [8*N-1:0]     req_x;
    logic [N-1:0]       req_mode;
    logic [N-1:0]       req_ready;
    logic               rom_en;
    logic [5:0]         rom_addr;
    logic [7:0]         rom_data = 8'd0;
    logic [7:0]         y_1, y_2, y_3;
    logic [1:0]         xlsb;
    logic [7:0]         lin_y, quad_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [7:0]         rsp_y;
    logic               busy;

    interp_lut_scheduler #(.N_REQ(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
        .req_mode(req_mode), .req_ready(req_ready), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .y_1(y_1), .y_2(y_2),
        .y_3(y_3), .xlsb(xlsb), .lin_y(lin_y), .quad_y(quad_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment: ROM and interpolators ----------------
    logic [7:0] rom [64];
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    function automatic logic [7:0] clamp8(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic [7:0] f_lin(input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        return clamp8(int'(a) + (((int'(b) - int'(a)) * int'(f)) >>> 2));
    endfunction

    // Newton forward difference with t = f/4, scaled by 32.
    function automatic logic [7:0] f_quad(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [1:0] f);
        int fi, d1, d2;
        fi = int'(f);
        d1 = int'(b) - int'(a);
        d2 = int'(c) - 2 * int'(b) + int'(a);
        return clamp8((32 * int'(a) + 8 * fi * d1 + fi * (fi - 4) * d2) >>> 5);
    endfunction

    assign lin_y  = f_lin(y_1, y_2, xlsb);
    assign quad_y = f_quad(y_1, y_2, y_3, xlsb);

    // ---------------- reference model ----------------
    typedef struct { logic [IDW-1:0] id; logic [7:0] y; } rsp_t;
    rsp_t exp_q[$];
    int   grant_log[$];
    int   rom_log[$];
    bit   granted_flag[N];
    int   m_ptr = N - 1;
    bit   outstanding = 1'b0;
    bit   mon_en = 1'b0;
    int   acc_cyc = 0;
    bit   acc_mode = 1'b0;
    bit   first_seen = 1'b1;
    int   last_hs_cyc = 0;
    int   last_grant_cyc = 0;
    bit   hold_v = 1'b0;
    logic [7:0]     hold_y;
    logic [IDW-1:0] hold_id;

    function automatic int sat(input int a);
        return (a > 63) ? 63 : a;
    endfunction

    function automatic logic [7:0] model_rsp(input logic [7:0] x, input logic m);
        int xm;
        xm = int'(x) / 4;
        if (m) return f_quad(rom[xm], rom[sat(xm + 1)], rom[sat(xm + 2)], x[1:0]);
        return f_lin(rom[xm], rom[sat(xm + 1)], x[1:0]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout (t=%0t)", nm, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        bit   was_out;
        int   w;
        int   idx;
        logic [N-1:0] exp_rdy;
        rsp_t e;
        if (mon_en) begin
            was_out = outstanding;
            if (rom_en) rom_log.push_back(int'(rom_addr));
            chk("busy", 32'(busy), 32'(was_out));
            if (hold_v) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_y", 32'(rsp_y), 32'(hold_y));
                chk("hold_id", 32'(rsp_id), 32'(hold_id));
            end
            hold_v = 1'b0;
            if (rsp_valid) begin
                if (!was_out || exp_q.size() == 0) begin
                    tmo("unexpected_rsp");
                end else begin
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        chk("latency", 32'(cyc - acc_cyc), acc_mode ? 32'd6 : 32'd5);
                    end
                    if (rsp_ready) begin
                        e = exp_q.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(e.id));
                        chk("rsp_y", 32'(rsp_y), 32'(e.y));
                        outstanding = 1'b0;
                        last_hs_cyc = cyc;
                    end else begin
                        hold_v  = 1'b1;
                        hold_y  = rsp_y;
                        hold_id = rsp_id;
                    end
                end
            end
            if (!rst_n || was_out) begin
                chk("req_ready_idle_only", 32'(req_ready), 32'd0);
            end else begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                exp_rdy = (w >= 0) ? N'(1 << w) : {N{1'b0}};
                chk("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (w >= 0) begin
                    m_ptr       = w;
                    outstanding = 1'b1;
                    acc_cyc     = cyc;
                    acc_mode    = req_mode[w];
                    first_seen  = 1'b0;
                    exp_q.push_back('{id: IDW'(w), y: model_rsp(req_x[8*w +: 8], req_mode[w])});
                    grant_log.push_back(w);
                    granted_flag[w] = 1'b1;
                    last_grant_cyc  = cyc;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int id, input logic [7:0] x, input logic m);
        req_x[8*id +: 8] = x;
        req_mode[id]     = m;
        req_valid[id]    = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (granted_flag[id]) begin
                granted_flag[id] = 1'b0;
                req_valid[id]    = 1'b0;
                return;
            end
        end
        req_valid[id] = 1'b0;
        tmo("grant_wait");
    endtask

    task automatic drain();
        for (int t = 0; t < 80; t++) begin
            @(posedge clk); #1;
            if (!outstanding && exp_q.size() == 0) return;
        end
        tmo("drain");
    endtask

    task automatic chk_addrs(input string nm, input int n, input int a0, input int a1, input int a2);
        int exp_a[3];
        exp_a = '{a0, a1, a2};
        chk({nm, "_count"}, 32'(rom_log.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rom_log.size()) chk({nm, "_addr"}, 32'(rom_log[i]), 32'(exp_a[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'(4 * i);
        for (int i = 0; i < N; i++) granted_flag[i] = 1'b0;
        rst_n     = 1'b0;
        req_valid = {N{1'b1}};
        req_x     = {(8*N){1'b0}};
        req_mode  = {N{1'b0}};
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = {N{1'b0}};
        mon_en    = 1'b1;
        @(negedge clk);
        chk("reset_outputs", 32'({rom_en, rom_addr, y_1, y_2, y_3, xlsb}), 32'd0);
        chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_y, busy, req_ready}), 32'd0);

        // Fairness: all four held high from the reset pointer.
        @(posedge clk); #1;
        req_x     = {8'h13, 8'h86, 8'h40, 8'h25};
        req_mode  = 4'b1010;
        req_valid = {N{1'b1}};
        for (int t = 0; t < 200 && grant_log.size() < 5; t++) begin
            @(posedge clk); #1;
        end
        req_valid = {N{1'b0}};
        chk("fair_count", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() >= 5) begin
            chk("fair_g0", 32'(grant_log[0]), 32'd0);
            chk("fair_g1", 32'(grant_log[1]), 32'd1);
            chk("fair_g2", 32'(grant_log[2]), 32'd2);
            chk("fair_g3", 32'(grant_log[3]), 32'd3);
            chk("fair_g4", 32'(grant_log[4]), 32'd0);
        end
        for (int i = 0; i < N; i++) granted_flag[i] = 1'b0;
        drain();

        // Ramp, linear and quadratic.
        rom_log.delete();
        issue(0, 8'h25, 1'b0);
        drain();
        chk_addrs("lin_ramp", 2, 9, 10, 0);
        chk("lin_y1", 32'(y_1), 32'd36);
        chk("lin_y2", 32'(y_2), 32'd40);
        chk("lin_xlsb", 32'(xlsb), 32'd1);

        rom_log.delete();
        issue(2, 8'h25, 1'b1);
        drain();
        chk_addrs("quad_ramp", 3, 9, 10, 11);
        chk("quad_y3", 32'(y_3), 32'd44);

        // Saturation at the top of the table.
        rom_log.delete();
        issue(3, 8'hFE, 1'b1);
        drain();
        chk_addrs("sat_fe", 3, 63, 63, 63);
        rom_log.delete();
        issue(1, 8'hF9, 1'b1);
        drain();
        chk_addrs("sat_f9", 3, 62, 63, 63);
        rom_log.delete();
        issue(0, 8'hFF, 1'b0);
        drain();
        chk_addrs("sat_ff_lin", 2, 63, 63, 0);

        // Backpressure: response held, waiting requester not accepted.
        rsp_ready = 1'b0;
        issue(0, 8'h5B, 1'b0);
        req_x[15:8]  = 8'h77;
        req_mode[1]  = 1'b1;
        req_valid[1] = 1'b1;
        begin
            int t;
            for (t = 0; t < 30 && !rsp_valid; t++) @(negedge clk);
            if (!rsp_valid) tmo("bp_rsp_valid");
        end
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        begin
            int t;
            for (t = 0; t < 30 && !granted_flag[1]; t++) begin
                @(posedge clk); #1;
            end
            if (!granted_flag[1]) tmo("bp_next_grant");
        end
        chk("bp_next_accept", 32'(last_grant_cyc - last_hs_cyc), 32'd1);
        granted_flag[1] = 1'b0;
        req_valid[1]    = 1'b0;
        drain();

        // Reset during RD1: transaction dropped, pointer back to N-1.
        issue(2, 8'hA6, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        exp_q.delete();
        outstanding = 1'b0;
        first_seen  = 1'b1;
        hold_v      = 1'b0;
        m_ptr       = N - 1;
        @(negedge clk);
        chk("midrst_outputs", 32'({rom_en, rom_addr, y_1, y_2, y_3, xlsb}), 32'd0);
        chk("midrst_rsp", 32'({rsp_valid, rsp_id, rsp_y, busy, req_ready}), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        grant_log.delete();
        req_x[15:8]  = 8'h31;
        req_mode[1]  = 1'b0;
        req_x[31:24] = 8'hC2;
        req_mode[3]  = 1'b1;
        req_valid    = 4'b1010;
        for (int t = 0; t < 100 && req_valid != 4'b0000; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (granted_flag[i]) begin
                    granted_flag[i] = 1'b0;
                    req_valid[i]    = 1'b0;
                end
            end
        end
        if (req_valid != 4'b0000) tmo("midrst_grants");
        req_valid = {N{1'b0}};
        if (grant_log.size() > 0) chk("midrst_first_grant", 32'(grant_log[0]), 32'd1);
        else tmo("midrst_first_grant");
        drain();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (granted_flag[i]) begin
                    granted_flag[i] = 1'b0;
                    req_valid[i]    = 1'b0;
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_x[8*i +: 8] = 8'($urandom_range(0, 255));
                    req_mode[i]     = 1'($urandom_range(0, 1));
                    req_valid[i]    = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
        req_valid = {N{1'b0}};
        rsp_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
